frog_game_ctrl: RTL and testbench

- Game sequencer for the frog/crocodile VGA game. Owns frog position, lives, score and game phase.
- Moves the frog once per video frame from the buttons and reacts to the collision flag from the renderer.
- Drives the respawn, blink and game-over sequencing that the pixel datapath consumes as frog_x/frog_y/frog_visible.

---
 rtl/frog_game_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_frog_game_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frog_game_ctrl.sv
// Game sequencer for the frog/crocodile VGA game: frog position, lives, score and phase.
// Moves the frog once per frame and runs the hit/blink, level-up and game-over sequences.
module frog_game_ctrl #(
    parameter int START_X    = 8,
    parameter int START_Y    = 240,
    parameter int MAX_X      = 607,
    parameter int MAX_Y      = 447,
    parameter int GOAL_X     = 576,
    parameter int STEP       = 2,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 60,
    parameter int WIN_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [8:0] frog_y,
    output logic       frog_visible,
    output logic [2:0] state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       collision_clr
);

    typedef enum logic [2:0] {
        S_ATTRACT   = 3'd0,
        S_PLAY      = 3'd1,
        S_HIT       = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int CNT_MAX = (HIT_FRAMES > WIN_FRAMES) ? HIT_FRAMES : WIN_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 16) ? $clog2(CNT_MAX) : 4;

    localparam logic [9:0]       X0       = 10'(START_X);
    localparam logic [8:0]       Y0       = 9'(START_Y);
    localparam logic [10:0]      XMAX_W   = 11'(MAX_X);
    localparam logic [9:0]       YMAX_W   = 10'(MAX_Y);
    localparam logic [9:0]       XMAX     = 10'(MAX_X);
    localparam logic [8:0]       YMAX     = 9'(MAX_Y);
    localparam logic [9:0]       GOAL     = 10'(GOAL_X);
    localparam logic [10:0]      STEP_X   = 11'(STEP);
    localparam logic [9:0]       STEP_Y   = 10'(STEP);
    localparam logic [1:0]       LIVES0   = 2'(LIVES);
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_FRAMES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_FRAMES - 1);

    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic             vis_q, vis_d;
    logic [1:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic             clr_q, clr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             start_q, armed_q, armed_d;
    logic             start_rise, one_btn, frame_last_hit, frame_last_win;

    logic [10:0] x_inc, x_dec;
    logic [9:0]  y_inc, y_dec;
    logic [9:0]  x_right, x_left;
    logic [8:0]  y_down, y_up;

    // A start level held through reset must be released before it counts as a press.
    assign start_rise     = btn_start & ~start_q & armed_q;
    assign armed_d        = armed_q | ~btn_start;
    assign one_btn        = $onehot({btn_up, btn_down, btn_left, btn_right});
    assign cnt_inc        = cnt_q + CNT_W'(1);
    assign frame_last_hit = frame_tick && (cnt_q == HIT_LAST);
    assign frame_last_win = frame_tick && (cnt_q == WIN_LAST);

    // One-bit-wider arithmetic so the clamp sees overflow and underflow.
    assign x_inc   = {1'b0, x_q} + STEP_X;
    assign x_dec   = {1'b0, x_q} - STEP_X;
    assign y_inc   = {1'b0, y_q} + STEP_Y;
    assign y_dec   = {1'b0, y_q} - STEP_Y;
    assign x_right = (x_inc > XMAX_W) ? XMAX : x_inc[9:0];
    assign x_left  = x_dec[10] ? 10'd0 : x_dec[9:0];
    assign y_down  = (y_inc > YMAX_W) ? YMAX : y_inc[8:0];
    assign y_up    = y_dec[9] ? 9'd0 : y_dec[8:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ATTRACT;
            x_q     <= X0;
            y_q     <= Y0;
            vis_q   <= 1'b1;
            lives_q <= 2'd0;
            score_q <= 8'd0;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            lives_q <= lives_d;
            score_q <= score_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            start_q <= btn_start;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ATTRACT:   if (start_rise) state_d = S_PLAY;
            S_PLAY: begin
                if (collision)      state_d = S_HIT;
                else if (x_q >= GOAL) state_d = S_LEVEL_UP;
            end
            S_HIT:       if (frame_last_hit) state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_PLAY;
            S_LEVEL_UP:  if (frame_last_win) state_d = S_PLAY;
            S_GAME_OVER: if (start_rise) state_d = S_ATTRACT;
            default:     state_d = S_ATTRACT;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vis_d   = vis_q;
        lives_d = lives_q;
        score_d = score_q;
        clr_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_ATTRACT: begin
                if (start_rise) begin
                    lives_d = LIVES0;
                    score_d = 8'd0;
                    x_d     = X0;
                    y_d     = Y0;
                    vis_d   = 1'b1;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_PLAY: begin
                if (collision) begin
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                end else if (x_q >= GOAL) begin
                    score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                    cnt_d   = '0;
                end else if (frame_tick && one_btn) begin
                    if (btn_up)    y_d = y_up;
                    if (btn_down)  y_d = y_down;
                    if (btn_left)  x_d = x_left;
                    if (btn_right) x_d = x_right;
                end
            end
            S_HIT: begin
                if (frame_last_hit) begin
                    cnt_d = '0;
                    if (lives_q == 2'd0) begin
                        vis_d = 1'b0;
                    end else begin
                        x_d   = X0;
                        y_d   = Y0;
                        vis_d = 1'b1;
                        clr_d = 1'b1;
                    end
                end else if (frame_tick) begin
                    cnt_d = cnt_inc;
                    vis_d = ~cnt_inc[3];
                end else begin
                    vis_d = ~cnt_q[3];
                end
            end
            S_LEVEL_UP: begin
                vis_d = 1'b1;
                if (frame_last_win) begin
                    cnt_d = '0;
                    x_d   = X0;
                    y_d   = Y0;
                    clr_d = 1'b1;
                end else if (frame_tick) begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAME_OVER: begin
                vis_d = 1'b0;
                if (start_rise) begin
                    x_d   = X0;
                    y_d   = Y0;
                    vis_d = 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign frog_x        = x_q;
    assign frog_y        = y_q;
    assign frog_visible  = vis_q;
    assign state         = state_q;
    assign lives         = lives_q;
    assign score         = score_q;
    assign collision_clr = clr_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Directed bench for frog_game_ctrl; a second instance with a short level runs score saturation.
module tb_frog_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_start = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] frog_x, sat_x;
    logic [8:0] frog_y, sat_y;
    logic       frog_visible, sat_vis;
    logic [2:0] state, sat_state;
    logic [1:0] lives, sat_lives;
    logic [7:0] score, sat_score;
    logic       collision_clr, sat_clr;

    int checks = 0;
    int errors = 0;

    frog_game_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .collision(collision),
        .frog_x(frog_x), .frog_y(frog_y), .frog_visible(frog_visible), .state(state),
        .lives(lives), .score(score), .collision_clr(collision_clr)
    );

    // Goal at the start column: every PLAY cycle clears a level, so saturation is quick to reach.
    frog_game_ctrl #(.GOAL_X(8), .WIN_FRAMES(2)) dut_sat (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .collision(collision),
        .frog_x(sat_x), .frog_y(sat_y), .frog_visible(sat_vis), .state(sat_state),
        .lives(sat_lives), .score(sat_score), .collision_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d want 0", lives); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (frog_x !== 10'd8 || frog_y !== 9'd240) begin errors++; $display("FAIL reset_pos: got (%0d,%0d) want (8,240)", frog_x, frog_y); end
        checks++; if (frog_visible !== 1'b1 || collision_clr !== 1'b0) begin errors++; $display("FAIL reset_flags: got vis=%0b clr=%0b want vis=1 clr=0", frog_visible, collision_clr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd1 || lives !== 2'd3 || score !== 8'd0) begin errors++; $display("FAIL start_enter: got state=%0d lives=%0d score=%0d want 1/3/0", state, lives, score); end
        checks++; if (frog_x !== 10'd8 || frog_y !== 9'd240 || collision_clr !== 1'b1) begin errors++; $display("FAIL start_pos_clr: got (%0d,%0d) clr=%0b want (8,240) clr=1", frog_x, frog_y, collision_clr); end
        @(negedge clk);
        checks++; if (collision_clr !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL start_clr_once: got clr=%0b state=%0d want clr=0 state=1", collision_clr, state); end
        btn_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_move();
        btn_right = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (frog_x !== 10'd8) begin errors++; $display("FAIL move_no_tick: got x=%0d want 8", frog_x); end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++; if (frog_x !== 10'd10) begin errors++; $display("FAIL move_latency: got x=%0d want 10", frog_x); end
        @(negedge clk);
        frames(9);
        checks++; if (frog_x !== 10'd28) begin errors++; $display("FAIL move_right10: got x=%0d want 28", frog_x); end
        btn_right = 1'b0;
        btn_up = 1'b1;
        frames(200);
        checks++; if (frog_y !== 9'd0) begin errors++; $display("FAIL move_up_clamp: got y=%0d want 0", frog_y); end
        btn_right = 1'b1;
        frames(5);
        checks++; if (frog_x !== 10'd28 || frog_y !== 9'd0) begin errors++; $display("FAIL move_two_btn: got (%0d,%0d) want (28,0)", frog_x, frog_y); end
        btn_right = 1'b0;
        btn_up = 1'b0;
        frames(3);
        checks++; if (frog_x !== 10'd28 || frog_y !== 9'd0) begin errors++; $display("FAIL move_no_btn: got (%0d,%0d) want (28,0)", frog_x, frog_y); end
        btn_down = 1'b1;
        frames(230);
        btn_down = 1'b0;
        checks++; if (frog_y !== 9'd447) begin errors++; $display("FAIL move_down_clamp: got y=%0d want 447", frog_y); end
    endtask

    task automatic test_hit();
        collision = 1'b1;
        frame_tick = 1'b1;
        btn_right = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        frame_tick = 1'b0;
        btn_right = 1'b0;
        checks++; if (state !== 3'd2 || lives !== 2'd2) begin errors++; $display("FAIL hit_enter: got state=%0d lives=%0d want 2/2", state, lives); end
        checks++; if (frog_x !== 10'd28 || collision_clr !== 1'b1) begin errors++; $display("FAIL hit_no_move_clr: got x=%0d clr=%0b want x=28 clr=1", frog_x, collision_clr); end
        @(negedge clk);
        frames(8);
        checks++; if (frog_visible !== 1'b0 || state !== 3'd2) begin errors++; $display("FAIL hit_blink8: got vis=%0b state=%0d want vis=0 state=2", frog_visible, state); end
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        checks++; if (lives !== 2'd2 || state !== 3'd2) begin errors++; $display("FAIL hit_ignore_coll: got lives=%0d state=%0d want 2/2", lives, state); end
        frames(8);
        checks++; if (frog_visible !== 1'b1) begin errors++; $display("FAIL hit_blink16: got vis=%0b want 1", frog_visible); end
        frames(43);
        checks++; if (state !== 3'd2 || frog_x !== 10'd28) begin errors++; $display("FAIL hit_hold59: got state=%0d x=%0d want 2/28", state, frog_x); end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++; if (state !== 3'd1 || frog_x !== 10'd8 || frog_y !== 9'd240) begin errors++; $display("FAIL hit_respawn: got state=%0d (%0d,%0d) want 1 (8,240)", state, frog_x, frog_y); end
        checks++; if (collision_clr !== 1'b1 || frog_visible !== 1'b1 || lives !== 2'd2) begin errors++; $display("FAIL hit_exit_flags: got clr=%0b vis=%0b lives=%0d want 1/1/2", collision_clr, frog_visible, lives); end
        @(negedge clk);
    endtask

    task automatic test_game_over();
        do_reset();
        press_start();
        for (int i = 0; i < 3; i++) begin
            collision = 1'b1;
            @(negedge clk);
            collision = 1'b0;
            checks++; if (lives !== 2'(2 - i)) begin errors++; $display("FAIL over_lives%0d: got %0d want %0d", i, lives, 2 - i); end
            frames(60);
        end
        checks++; if (state !== 3'd4 || lives !== 2'd0 || frog_visible !== 1'b0) begin errors++; $display("FAIL over_enter: got state=%0d lives=%0d vis=%0b want 4/0/0", state, lives, frog_visible); end
        btn_start = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd0 || frog_visible !== 1'b1 || frog_x !== 10'd8) begin errors++; $display("FAIL over_to_attract: got state=%0d vis=%0b x=%0d want 0/1/8", state, frog_visible, frog_x); end
        btn_start = 1'b0;
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        checks++; if (state !== 3'd1 || lives !== 2'd3 || score !== 8'd0) begin errors++; $display("FAIL over_restart: got state=%0d lives=%0d score=%0d want 1/3/0", state, lives, score); end
        @(negedge clk);
    endtask

    task automatic test_level_up();
        btn_right = 1'b1;
        frames(284);
        checks++; if (state !== 3'd3 || score !== 8'd1 || frog_x !== 10'd576) begin errors++; $display("FAIL lvl_enter: got state=%0d score=%0d x=%0d want 3/1/576", state, score, frog_x); end
        btn_right = 1'b0;
        frames(119);
        checks++; if (state !== 3'd3 || frog_visible !== 1'b1) begin errors++; $display("FAIL lvl_hold: got state=%0d vis=%0b want 3/1", state, frog_visible); end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++; if (state !== 3'd1 || frog_x !== 10'd8 || frog_y !== 9'd240) begin errors++; $display("FAIL lvl_exit: got state=%0d (%0d,%0d) want 1 (8,240)", state, frog_x, frog_y); end
        checks++; if (lives !== 2'd3 || collision_clr !== 1'b1 || score !== 8'd1) begin errors++; $display("FAIL lvl_exit_flags: got lives=%0d clr=%0b score=%0d want 3/1/1", lives, collision_clr, score); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_hit();
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
        frames(30);
        checks++; if (state !== 3'd2 || frog_visible !== 1'b0) begin errors++; $display("FAIL rmid_pre: got state=%0d vis=%0b want 2/0", state, frog_visible); end
        rst = 1'b1;
        btn_start = 1'b1;
        @(negedge clk);
        checks++; if (state !== 3'd0 || lives !== 2'd0 || score !== 8'd0) begin errors++; $display("FAIL rmid_regs: got state=%0d lives=%0d score=%0d want 0/0/0", state, lives, score); end
        checks++; if (frog_x !== 10'd8 || frog_y !== 9'd240 || frog_visible !== 1'b1) begin errors++; $display("FAIL rmid_frog: got (%0d,%0d) vis=%0b want (8,240) 1", frog_x, frog_y, frog_visible); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rmid_held_start: got state=%0d want 0", state); end
        btn_start = 1'b0;
        @(negedge clk);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        checks++; if (state !== 3'd1 || lives !== 2'd3) begin errors++; $display("FAIL rmid_repress: got state=%0d lives=%0d want 1/3", state, lives); end
        @(negedge clk);
    endtask

    task automatic test_score_saturate();
        do_reset();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        frame_tick = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (sat_score !== 8'd10) begin errors++; $display("FAIL sat_rate: got score=%0d want 10", sat_score); end
        repeat (900) @(negedge clk);
        checks++; if (sat_score !== 8'd255) begin errors++; $display("FAIL sat_cap: got score=%0d want 255", sat_score); end
        repeat (7) @(negedge clk);
        checks++; if (sat_score !== 8'd255 || (sat_state !== 3'd1 && sat_state !== 3'd3)) begin errors++; $display("FAIL sat_hold: got score=%0d state=%0d want 255 in 1/3", sat_score, sat_state); end
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_start();
        test_move();
        test_hit();
        test_game_over();
        test_level_up();
        test_reset_mid_hit();
        test_score_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
